next_pc_unit: RTL and testbench

//  Parametrised next-PC generator for the MIPS fetch stage; it supersedes the combinational jump-address splice.

---
 rtl/next_pc_unit_pkg.sv | 22 ++
 rtl/next_pc_unit_ras_stack.sv | 64 ++++++
 rtl/next_pc_unit.sv | 106 ++++++++++
 tb/tb_next_pc_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/next_pc_unit_pkg.sv
// Shared definitions for the fetch-stage next-PC unit: mode codes and small helpers.
// Fetch and the control decoder use the same mode encoding.
package next_pc_unit_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ  = 3'd0,
        NPC_BR   = 3'd1,
        NPC_J    = 3'd2,
        NPC_JAL  = 3'd3,
        NPC_JR   = 3'd4,
        NPC_JALR = 3'd5,
        NPC_RET  = 3'd6
    } npc_mode_e;

    localparam int JUMP_REGION_LSB = 28;

    // Modes that write the link value into the return-address stack.
    function automatic logic npc_is_call(input logic [2:0] mode);
        return (mode == NPC_JAL) || (mode == NPC_JALR);
    endfunction

endpackage

// File: rtl/next_pc_unit_ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is ignored, and the count saturates at DEPTH.
module ras_stack
    import next_pc_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               push_data,
    output logic [W-1:0]               top,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] top_idx;
    logic             full;
    logic             empty;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign top_idx = ptr_q - PTR_W'(1);
    // Top is read combinationally so a return can redirect in the cycle it is decoded.
    assign top     = mem_q[top_idx];
    assign count   = count_q;

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push) begin
            ptr_d   = ptr_q + PTR_W'(1);
            count_d = full ? count_q : count_q + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr_d   = top_idx;
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left uncleared by reset; the count gates what is reachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// MIPS fetch next-PC generator: PC register, target selection, link value,
// redirect/alignment flags and a return-address stack for fast returns.
module next_pc_unit
    import next_pc_unit_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall_i,
    input  logic [2:0]                   mode_i,
    input  logic                         br_taken_i,
    input  logic [15:0]                  imm_i,
    input  logic [25:0]                  instr_index_i,
    input  logic [ADDR_W-1:0]            rs_val_i,
    output logic [ADDR_W-1:0]            pc_o,
    output logic [ADDR_W-1:0]            link_o,
    output logic                         redirect_o,
    output logic                         addr_err_o,
    output logic [$clog2(RAS_DEPTH):0]   ras_cnt_o
);

    localparam logic [ADDR_W-1:0] RESET_PC_EXT = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0]          pc_q, pc_d;
    logic                       redirect_q, redirect_d;
    logic                       addr_err_q, addr_err_d;
    logic [ADDR_W-1:0]          pc_plus4;
    logic [ADDR_W-1:0]          br_offset;
    logic [ADDR_W-1:0]          jump_target;
    logic [ADDR_W-1:0]          reg_target;
    logic [ADDR_W-1:0]          ras_top;
    logic [$clog2(RAS_DEPTH):0] ras_count;
    logic                       ras_push;
    logic                       ras_pop;

    assign pc_plus4    = pc_q + ADDR_W'(4);
    assign br_offset   = {{(ADDR_W-18){imm_i[15]}}, imm_i, 2'b00};
    assign jump_target = {pc_plus4[ADDR_W-1:JUMP_REGION_LSB], instr_index_i, 2'b00};
    assign reg_target  = {rs_val_i[ADDR_W-1:2], 2'b00};

    assign ras_push = !stall_i && npc_is_call(mode_i);
    assign ras_pop  = !stall_i && (mode_i == NPC_RET) && (ras_count != '0);

    always_comb begin
        pc_d       = pc_plus4;
        addr_err_d = 1'b0;
        if (stall_i) begin
            pc_d = pc_q;
        end else begin
            case (mode_i)
                NPC_BR:            pc_d = br_taken_i ? pc_plus4 + br_offset : pc_plus4;
                NPC_J, NPC_JAL:    pc_d = jump_target;
                NPC_JR, NPC_JALR: begin
                    pc_d       = reg_target;
                    addr_err_d = (rs_val_i[1:0] != 2'b00);
                end
                NPC_RET: begin
                    // Empty stack falls back to the register operand, like JR.
                    if (ras_count != '0) begin
                        pc_d = ras_top;
                    end else begin
                        pc_d       = reg_target;
                        addr_err_d = (rs_val_i[1:0] != 2'b00);
                    end
                end
                default:           pc_d = pc_plus4;
            endcase
        end
        redirect_d = !stall_i && (pc_d != pc_plus4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC_EXT;
            redirect_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            addr_err_q <= addr_err_d;
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .count     (ras_count)
    );

    assign pc_o       = pc_q;
    assign link_o     = pc_plus4;
    assign redirect_o = redirect_q;
    assign addr_err_o = addr_err_q;
    assign ras_cnt_o  = ras_count;

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_next_pc_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic [2:0]  mode_i;
    logic        br_taken_i;
    logic [15:0] imm_i;
    logic [25:0] instr_index_i;
    logic [31:0] rs_val_i;
    logic [31:0] pc_o;
    logic [31:0] link_o;
    logic        redirect_o;
    logic        addr_err_o;
    logic [2:0]  ras_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_redirect;
    logic        m_err;
    logic [31:0] m_ras [$];

    next_pc_unit #(
        .ADDR_W    (32),
        .RESET_PC  (32'h0000_0000),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .mode_i        (mode_i),
        .br_taken_i    (br_taken_i),
        .imm_i         (imm_i),
        .instr_index_i (instr_index_i),
        .rs_val_i      (rs_val_i),
        .pc_o          (pc_o),
        .link_o        (link_o),
        .redirect_o    (redirect_o),
        .addr_err_o    (addr_err_o),
        .ras_cnt_o     (ras_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc       = 32'h0;
        m_redirect = 1'b0;
        m_err      = 1'b0;
        m_ras.delete();
    endtask

    // Drives one instruction, advances the model, then waits until just after the edge.
    task automatic apply(input logic [2:0] mode, input logic taken, input logic [15:0] imm,
                         input logic [25:0] idx, input logic [31:0] rs, input logic stall);
        logic [31:0] p4;
        logic [31:0] nxt;
        mode_i        = mode;
        br_taken_i    = taken;
        imm_i         = imm;
        instr_index_i = idx;
        rs_val_i      = rs;
        stall_i       = stall;
        p4    = m_pc + 32'd4;
        nxt   = p4;
        m_err = 1'b0;
        if (stall) begin
            nxt = m_pc;
        end else begin
            case (mode)
                3'd1: if (taken) nxt = p4 + 32'(int'($signed(imm)) * 4);
                3'd2, 3'd3: nxt = (p4 & 32'hF000_0000) | (32'(idx) * 4);
                3'd4, 3'd5: begin
                    nxt   = rs & ~32'h3;
                    m_err = (rs % 4) != 0;
                end
                3'd6: begin
                    if (m_ras.size() > 0) begin
                        nxt = m_ras.pop_back();
                    end else begin
                        nxt   = rs & ~32'h3;
                        m_err = (rs % 4) != 0;
                    end
                end
                default: nxt = p4;
            endcase
            if (mode == 3'd3 || mode == 3'd5) begin
                if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
                m_ras.push_back(p4);
            end
        end
        m_redirect = !stall && (nxt != p4);
        m_pc       = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        apply_idle();
        model_reset();
        #12;
        n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); end
        n_cmp++; if (redirect_o !== 1'b0) begin n_err++; $display("FAIL reset_redirect: got %b want 0", redirect_o); end
        n_cmp++; if (addr_err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", addr_err_o); end
        n_cmp++; if (ras_cnt_o !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", ras_cnt_o); end
        n_cmp++; if (link_o !== 32'h4) begin n_err++; $display("FAIL reset_link: got %h want %h", link_o, 32'h4); end
        rst_n = 1'b1;
        $display("reset: pc=%h cnt=%0d", pc_o, ras_cnt_o);
    endtask

    task automatic apply_idle();
        mode_i = 3'd0; br_taken_i = 1'b0; imm_i = '0; instr_index_i = '0; rs_val_i = '0; stall_i = 1'b0;
    endtask

    task automatic test_seq();
        for (int i = 1; i <= 3; i++) begin
            apply(3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
            $display("seq: pc=%h redirect=%b", pc_o, redirect_o);
            n_cmp++; if (pc_o !== 32'(4 * i)) begin n_err++; $display("FAIL seq_pc: got %h want %h", pc_o, 32'(4 * i)); end
            n_cmp++; if (redirect_o !== 1'b0) begin n_err++; $display("FAIL seq_redirect: got %b want 0", redirect_o); end
        end
    endtask

    task automatic test_branch();
        apply(3'd4, 1'b0, 16'h0, 26'h0, 32'h100, 1'b0);
        apply(3'd1, 1'b1, 16'hFFFE, 26'h0, 32'h0, 1'b0);
        $display("br_taken: pc=%h redirect=%b", pc_o, redirect_o);
        n_cmp++; if (pc_o !== 32'hFC) begin n_err++; $display("FAIL br_taken_pc: got %h want %h", pc_o, 32'hFC); end
        n_cmp++; if (redirect_o !== 1'b1) begin n_err++; $display("FAIL br_taken_redirect: got %b want 1", redirect_o); end
        apply(3'd1, 1'b0, 16'h0040, 26'h0, 32'h0, 1'b0);
        $display("br_not_taken: pc=%h redirect=%b", pc_o, redirect_o);
        n_cmp++; if (pc_o !== 32'h100) begin n_err++; $display("FAIL br_nt_pc: got %h want %h", pc_o, 32'h100); end
        n_cmp++; if (redirect_o !== 1'b0) begin n_err++; $display("FAIL br_nt_redirect: got %b want 0", redirect_o); end
        apply(3'd1, 1'b1, 16'h0000, 26'h0, 32'h0, 1'b0);
        $display("br_imm0: pc=%h redirect=%b", pc_o, redirect_o);
        n_cmp++; if (pc_o !== 32'h104) begin n_err++; $display("FAIL br_imm0_pc: got %h want %h", pc_o, 32'h104); end
        n_cmp++; if (redirect_o !== 1'b0) begin n_err++; $display("FAIL br_imm0_redirect: got %b want 0", redirect_o); end
    endtask

    task automatic test_jal_ret();
        apply(3'd4, 1'b0, 16'h0, 26'h0, 32'h3000_0010, 1'b0);
        apply(3'd3, 1'b0, 16'h0, 26'h0000040, 32'h0, 1'b0);
        $display("jal: pc=%h cnt=%0d", pc_o, ras_cnt_o);
        n_cmp++; if (pc_o !== 32'h3000_0100) begin n_err++; $display("FAIL jal_pc: got %h want %h", pc_o, 32'h3000_0100); end
        n_cmp++; if (ras_cnt_o !== 3'd1) begin n_err++; $display("FAIL jal_cnt: got %0d want 1", ras_cnt_o); end
        apply(3'd6, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        $display("ret: pc=%h cnt=%0d", pc_o, ras_cnt_o);
        n_cmp++; if (pc_o !== 32'h3000_0014) begin n_err++; $display("FAIL ret_pc: got %h want %h", pc_o, 32'h3000_0014); end
        n_cmp++; if (ras_cnt_o !== 3'd0) begin n_err++; $display("FAIL ret_cnt: got %0d want 0", ras_cnt_o); end
        n_cmp++; if (redirect_o !== 1'b1) begin n_err++; $display("FAIL ret_redirect: got %b want 1", redirect_o); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] links [5];
        for (int k = 0; k < 5; k++) begin
            links[k] = m_pc + 32'd4;
            apply(3'd3, 1'b0, 16'h0, 26'(32'h10 * (k + 1)), 32'h0, 1'b0);
        end
        $display("ras_fill: cnt=%0d", ras_cnt_o);
        n_cmp++; if (ras_cnt_o !== 3'd4) begin n_err++; $display("FAIL ras_full_cnt: got %0d want 4", ras_cnt_o); end
        for (int k = 4; k >= 1; k--) begin
            apply(3'd6, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
            $display("ras_pop: pc=%h cnt=%0d", pc_o, ras_cnt_o);
            n_cmp++; if (pc_o !== links[k]) begin n_err++; $display("FAIL ras_ret_pc: got %h want %h", pc_o, links[k]); end
        end
        apply(3'd6, 1'b0, 16'h0, 26'h0, 32'h200, 1'b0);
        $display("ras_empty_ret: pc=%h cnt=%0d", pc_o, ras_cnt_o);
        n_cmp++; if (pc_o !== 32'h200) begin n_err++; $display("FAIL ras_fallback_pc: got %h want %h", pc_o, 32'h200); end
        n_cmp++; if (ras_cnt_o !== 3'd0) begin n_err++; $display("FAIL ras_empty_cnt: got %0d want 0", ras_cnt_o); end
    endtask

    task automatic test_jr_stall();
        apply(3'd3, 1'b0, 16'h0, 26'h0000100, 32'h0, 1'b0);
        apply(3'd4, 1'b0, 16'h0, 26'h0, 32'h403, 1'b0);
        $display("jr_misaligned: pc=%h err=%b", pc_o, addr_err_o);
        n_cmp++; if (pc_o !== 32'h400) begin n_err++; $display("FAIL jr_pc: got %h want %h", pc_o, 32'h400); end
        n_cmp++; if (addr_err_o !== 1'b1) begin n_err++; $display("FAIL jr_err: got %b want 1", addr_err_o); end
        apply(3'd2, 1'b1, 16'h0, 26'h3FFFFFF, 32'h0, 1'b1);
        $display("stall: pc=%h redirect=%b err=%b cnt=%0d", pc_o, redirect_o, addr_err_o, ras_cnt_o);
        n_cmp++; if (pc_o !== 32'h400) begin n_err++; $display("FAIL stall_pc: got %h want %h", pc_o, 32'h400); end
        n_cmp++; if (redirect_o !== 1'b0) begin n_err++; $display("FAIL stall_redirect: got %b want 0", redirect_o); end
        n_cmp++; if (addr_err_o !== 1'b0) begin n_err++; $display("FAIL stall_err: got %b want 0", addr_err_o); end
        n_cmp++; if (ras_cnt_o !== 3'd1) begin n_err++; $display("FAIL stall_cnt: got %0d want 1", ras_cnt_o); end
        apply(3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        n_cmp++; if (pc_o !== 32'h404) begin n_err++; $display("FAIL post_stall_pc: got %h want %h", pc_o, 32'h404); end
    endtask

    task automatic test_wrap_reset();
        apply(3'd4, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0);
        apply(3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        $display("wrap: pc=%h", pc_o);
        n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want %h", pc_o, 32'h0); end
        apply(3'd3, 1'b0, 16'h0, 26'h0000123, 32'h0, 1'b0);
        mode_i = 3'd3; instr_index_i = 26'h0000456;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        $display("mid_reset: pc=%h cnt=%0d", pc_o, ras_cnt_o);
        n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL async_reset_pc: got %h want %h", pc_o, 32'h0); end
        n_cmp++; if (ras_cnt_o !== 3'd0) begin n_err++; $display("FAIL async_reset_cnt: got %0d want 0", ras_cnt_o); end
        #2;
        rst_n = 1'b1;
        apply(3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        $display("post_reset: pc=%h", pc_o);
        n_cmp++; if (pc_o !== 32'h4) begin n_err++; $display("FAIL post_reset_pc: got %h want %h", pc_o, 32'h4); end
    endtask

    task automatic test_random();
        logic [2:0]  mode;
        logic [31:0] rs;
        logic        stall;
        for (int i = 0; i < 400; i++) begin
            mode  = 3'($urandom_range(0, 7));
            stall = ($urandom_range(0, 7) == 0);
            rs    = $urandom;
            if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
            apply(mode, 1'($urandom), 16'($urandom), 26'($urandom), rs, stall);
            $display("rand %0d: mode=%0d stall=%b pc=%h redir=%b err=%b cnt=%0d",
                     i, mode, stall, pc_o, redirect_o, addr_err_o, ras_cnt_o);
            n_cmp++; if (pc_o !== m_pc) begin n_err++; $display("FAIL rand_pc: got %h want %h", pc_o, m_pc); end
            n_cmp++; if (redirect_o !== m_redirect) begin n_err++; $display("FAIL rand_redirect: got %b want %b", redirect_o, m_redirect); end
            n_cmp++; if (addr_err_o !== m_err) begin n_err++; $display("FAIL rand_err: got %b want %b", addr_err_o, m_err); end
            n_cmp++; if (ras_cnt_o !== 3'(m_ras.size())) begin n_err++; $display("FAIL rand_cnt: got %0d want %0d", ras_cnt_o, m_ras.size()); end
            n_cmp++; if (link_o !== m_pc + 32'd4) begin n_err++; $display("FAIL rand_link: got %h want %h", link_o, m_pc + 32'd4); end
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_jal_ret();
        test_ras_overflow();
        test_jr_stall();
        test_wrap_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
